// File: rtl/cache_seq_gen_if.sv
// Cache request/response channel between the traffic generator (master) and the cache (slave).
interface cache_seq_gen_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OPQ_W  = 8
);
    logic              cachereq_val;
    logic              cachereq_rdy;
    logic [2:0]        cachereq_type;
    logic [OPQ_W-1:0]  cachereq_opaque;
    logic [ADDR_W-1:0] cachereq_addr;
    logic [1:0]        cachereq_len;
    logic [DATA_W-1:0] cachereq_data;

    logic              cacheresp_val;
    logic              cacheresp_rdy;
    logic [2:0]        cacheresp_type;
    logic [OPQ_W-1:0]  cacheresp_opaque;
    logic [DATA_W-1:0] cacheresp_data;

    modport master (
        output cachereq_val, cachereq_type, cachereq_opaque, cachereq_addr,
               cachereq_len, cachereq_data, cacheresp_rdy,
        input  cachereq_rdy, cacheresp_val, cacheresp_type, cacheresp_opaque,
               cacheresp_data
    );

    modport slave (
        input  cachereq_val, cachereq_type, cachereq_opaque, cachereq_addr,
               cachereq_len, cachereq_data, cacheresp_rdy,
        output cachereq_rdy, cacheresp_val, cacheresp_type, cacheresp_opaque,
               cacheresp_data
    );
endinterface

// File: rtl/cache_seq_gen.sv
// Sequential cache traffic generator/checker: read, write or write-then-verify passes.
// Define CACHE_SEQ_GEN_BACKPRESSURE_EN for LFSR-driven response backpressure.
module cache_seq_gen #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int OPQ_W           = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STRIDE          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_num,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [15:0]       resp_cnt,
    cache_seq_gen_if.master   bus
);
    // state    | meaning
    // IDLE     | waiting for start
    // WR       | issuing the write pass
    // WR_DRAIN | writes issued, waiting for their responses
    // RD       | issuing the read pass
    // RD_DRAIN | reads issued, waiting for their responses
    // FIN      | done pulse, then back to IDLE
    typedef enum logic [2:0] {IDLE, WR, WR_DRAIN, RD, RD_DRAIN, FIN} state_t;

    localparam logic [2:0]        TYPE_READ  = 3'd0;
    localparam logic [2:0]        TYPE_WRITE = 3'd1;
    localparam logic [3:0]        OUT_MAX    = 4'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(STRIDE);

    state_t            state, state_nxt;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       num_q;
    logic [15:0]       issued;
    logic [ADDR_W-1:0] req_addr;
    logic [OPQ_W-1:0]  req_opq;
    logic [3:0]        outstanding;
    logic [ADDR_W-1:0] exp_addr;
    logic [OPQ_W-1:0]  exp_opq;
    logic [DATA_W-1:0] req_word;
    logic [DATA_W-1:0] exp_word;
    logic              req_val, req_fire;
    logic              resp_rdy, resp_fire, resp_err;
    logic              launch, enter_rd, pass_wr;

    generate
        if (DATA_W > ADDR_W) begin : g_pad
            assign req_word = {{(DATA_W-ADDR_W){1'b0}}, req_addr};
            assign exp_word = {{(DATA_W-ADDR_W){1'b0}}, exp_addr};
        end else begin : g_trunc
            assign req_word = req_addr[DATA_W-1:0];
            assign exp_word = exp_addr[DATA_W-1:0];
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        req_val   = 1'b0;
        launch    = 1'b0;
        enter_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    launch = 1'b1;
                    if (word_num == 16'd0)
                        state_nxt = FIN;
                    else if (mode == 2'd1 || mode == 2'd2)
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            WR: begin
                req_val = (issued < num_q) && (outstanding < OUT_MAX);
                if (issued == num_q)
                    state_nxt = WR_DRAIN;
            end
            WR_DRAIN: begin
                if (outstanding == 4'd0) begin
                    if (mode_q == 2'd2) begin
                        state_nxt = RD;
                        enter_rd  = 1'b1;
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            RD: begin
                req_val = (issued < num_q) && (outstanding < OUT_MAX);
                if (issued == num_q)
                    state_nxt = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (outstanding == 4'd0)
                    state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign pass_wr = (state == WR) || (state == WR_DRAIN);

    assign bus.cachereq_val    = req_val;
    assign bus.cachereq_type   = (state == WR) ? TYPE_WRITE : TYPE_READ;
    assign bus.cachereq_opaque = req_opq;
    assign bus.cachereq_addr   = req_addr;
    assign bus.cachereq_len    = 2'd0;
    assign bus.cachereq_data   = (state == WR) ? req_word : '0;
    assign bus.cacheresp_rdy   = resp_rdy;

    assign req_fire  = req_val && bus.cachereq_rdy;
    assign resp_fire = bus.cacheresp_val && resp_rdy;
    assign resp_err  = (bus.cacheresp_opaque != exp_opq)
                    || (bus.cacheresp_type != (pass_wr ? TYPE_WRITE : TYPE_READ))
                    || (!pass_wr && (bus.cacheresp_data != exp_word));

`ifdef CACHE_SEQ_GEN_BACKPRESSURE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign resp_rdy = (lfsr[1:0] != 2'b00);
`else
    assign resp_rdy = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Responses with nothing outstanding (stale traffic) must not underflow the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= 4'd0;
        end else begin
            case ({req_fire, resp_fire && busy && (outstanding != 4'd0)})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= 2'd0;
            base_q   <= '0;
            num_q    <= 16'd0;
            issued   <= 16'd0;
            req_addr <= '0;
            req_opq  <= '0;
            exp_addr <= '0;
            exp_opq  <= '0;
            err_cnt  <= 16'd0;
            resp_cnt <= 16'd0;
        end else if (launch) begin
            mode_q   <= mode;
            base_q   <= base_addr;
            num_q    <= word_num;
            issued   <= 16'd0;
            req_addr <= base_addr;
            req_opq  <= '0;
            exp_addr <= base_addr;
            exp_opq  <= '0;
            err_cnt  <= 16'd0;
            resp_cnt <= 16'd0;
        end else if (enter_rd) begin
            issued   <= 16'd0;
            req_addr <= base_q;
            req_opq  <= '0;
            exp_addr <= base_q;
            exp_opq  <= '0;
        end else begin
            if (req_fire) begin
                issued   <= issued + 16'd1;
                req_addr <= req_addr + ADDR_STEP;
                req_opq  <= req_opq + 1'b1;
            end
            if (resp_fire && busy) begin
                resp_cnt <= resp_cnt + 16'd1;
                exp_addr <= exp_addr + ADDR_STEP;
                exp_opq  <= exp_opq + 1'b1;
                if (resp_err && (err_cnt != 16'hFFFF))
                    err_cnt <= err_cnt + 16'd1;
            end
        end
    end
endmodule
